// File: rtl/dz_csr_n_pkg.sv
// DZ CSR shared definitions: CSR bit positions, scanner state encoding,
// line-index width and CLR one-shot count helpers.
package dz_csr_n_pkg;

  localparam int unsigned CSR_TRDY  = 15;
  localparam int unsigned CSR_TIE   = 14;
  localparam int unsigned CSR_SA    = 13;
  localparam int unsigned CSR_SAE   = 12;
  localparam int unsigned CSR_TLINE = 8;   // TLINE occupies 11:8
  localparam int unsigned CSR_RDONE = 7;
  localparam int unsigned CSR_RIE   = 6;
  localparam int unsigned CSR_MSE   = 5;
  localparam int unsigned CSR_CLR   = 4;
  localparam int unsigned CSR_MAINT = 3;

  typedef enum logic [1:0] {
    SCAN = 2'd0,
    HOLD = 2'd1,
    WAIT = 2'd2
  } scanState_t;

  // Bits needed to index nlines lines (log2 of the line count).
  function automatic int unsigned lineBits(input int unsigned nlines);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < nlines) w++;
    return w;
  endfunction

  // CLR one-shot length in clocks.
  function automatic int unsigned clrCount(input int unsigned clkfrq, input int unsigned clrus);
    logic [63:0] p;
    p = (64'(clkfrq) * 64'(clrus)) / 64'd1000000;
    return 32'(p);
  endfunction

  // Counter width able to hold cnt (at least one bit).
  function automatic int unsigned clrWidth(input int unsigned cnt);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) <= 64'(cnt)) w++;
    return w;
  endfunction

endpackage

// File: rtl/dz_csr_n_if.sv
// DZ UBA register bus: byte lanes, write data, CSR/TDR strobes and CSR read value.
//   master: bus side (drives strobes/data, reads regCSR)
//   slave : CSR block
interface dz_csr_n_if;
  logic        devRESET;
  logic        devLOBYTE;
  logic        devHIBYTE;
  logic [0:35] devDATAI;
  logic        csrWRITE;
  logic        tdrWRITE;
  logic [15:0] regCSR;

  modport master (
    output devRESET, devLOBYTE, devHIBYTE, devDATAI, csrWRITE, tdrWRITE,
    input  regCSR
  );

  modport slave (
    input  devRESET, devLOBYTE, devHIBYTE, devDATAI, csrWRITE, tdrWRITE,
    output regCSR
  );
endinterface

// File: rtl/dz_rrarb.sv
// Single-cycle round-robin selector: returns the first set request found
// searching ptr, ptr+1, ... with wrap.
//   req   : request vector (N lines, N a power of two)
//   ptr   : search start index
//   grant : selected line index
//   valid : any request set
module dz_rrarb #(
  parameter int unsigned N  = 8,
  parameter int unsigned LB = 3
) (
  input  logic [N-1:0]  req,
  input  logic [LB-1:0] ptr,
  output logic [LB-1:0] grant,
  output logic          valid
);

  logic [LB-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest match wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      idx = ptr + LB'(i);
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dz_csr_n.sv
// DZ control/status register with transmitter line scanner and CLR one-shot.
//   clk, rst_n          : clock, async active-low reset
//   bus                 : UBA register bus (slave side), regCSR read value
//   rbufRDONE, rbufSA   : receiver done / silo alarm
//   uartTXEMPTY, tcrLIN : per-line transmitter empty / line enable
//   csrCLR, csrMAINT    : clear in progress / maintenance loopback
//   txINTR, rxINTR      : interrupt request levels
module dz_csr_n
  import dz_csr_n_pkg::*;
#(
  parameter int unsigned NLINES   = 8,
  parameter int unsigned CLKFRQ   = 60000000,
  parameter int unsigned CLRUS    = 3,
  parameter int unsigned SCANMODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  dz_csr_n_if.slave         bus,
  input  logic              rbufRDONE,
  input  logic              rbufSA,
  input  logic [NLINES-1:0] uartTXEMPTY,
  input  logic [NLINES-1:0] tcrLIN,
  output logic              csrCLR,
  output logic              csrMAINT,
  output logic              txINTR,
  output logic              rxINTR
);

  localparam int unsigned LB     = lineBits(NLINES);
  localparam int unsigned CLRCNT = clrCount(CLKFRQ, CLRUS);
  localparam int unsigned CW     = clrWidth(CLRCNT);

  logic [15:0]   wrData;
  logic          unusedBits;
  logic          csrLo, csrHi, tdrLo, clrStart, holdOff;
  logic [CW-1:0] clrCnt;
  logic          tie, sae, rie, mse, maint;
  scanState_t    state, stateNx;
  logic [LB-1:0] ptr, ptrNx, tline, tlineNx;
  logic [NLINES-1:0] elig;
  logic [LB-1:0] arbGrant;
  logic          arbValid;
  logic          trdy;

  // CSR bit n arrives on devDATAI[35-n], so the [20:35] slice is already CSR order.
  assign wrData     = bus.devDATAI[20:35];
  assign unusedBits = ^bus.devDATAI[0:19];

  assign csrLo    = bus.csrWRITE & bus.devLOBYTE;
  assign csrHi    = bus.csrWRITE & bus.devHIBYTE;
  assign tdrLo    = bus.tdrWRITE & bus.devLOBYTE;
  assign clrStart = csrLo & wrData[CSR_CLR];
  // A clear starting this cycle already suppresses the R/W bits and scanner.
  assign holdOff  = bus.devRESET | csrCLR | clrStart;

  // CLR one-shot counter; device reset wins over a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               clrCnt <= '0;
    else if (bus.devRESET)    clrCnt <= '0;
    else if (clrStart)        clrCnt <= CW'(CLRCNT);
    else if (clrCnt != '0)    clrCnt <= clrCnt - CW'(1);
  end

  assign csrCLR = (clrCnt != '0);

  // R/W control bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tie   <= 1'b0;
      sae   <= 1'b0;
      rie   <= 1'b0;
      mse   <= 1'b0;
      maint <= 1'b0;
    end else if (holdOff) begin
      tie   <= 1'b0;
      sae   <= 1'b0;
      rie   <= 1'b0;
      mse   <= 1'b0;
      maint <= 1'b0;
    end else begin
      if (csrHi) begin
        tie <= wrData[CSR_TIE];
        sae <= wrData[CSR_SAE];
      end
      if (csrLo) begin
        rie   <= wrData[CSR_RIE];
        mse   <= wrData[CSR_MSE];
        maint <= wrData[CSR_MAINT];
      end
    end
  end

  assign elig = tcrLIN & uartTXEMPTY;

  dz_rrarb #(
    .N  (NLINES),
    .LB (LB)
  ) uArb (
    .req   (elig),
    .ptr   (ptr),
    .grant (arbGrant),
    .valid (arbValid)
  );

  // Scanner state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SCAN;
      ptr   <= '0;
      tline <= '0;
    end else begin
      state <= stateNx;
      ptr   <= ptrNx;
      tline <= tlineNx;
    end
  end

  // Scanner next-state logic.
  always_comb begin
    stateNx = state;
    ptrNx   = ptr;
    tlineNx = tline;
    if (holdOff) begin
      stateNx = SCAN;
      ptrNx   = '0;
      tlineNx = '0;
    end else begin
      case (state)
        SCAN: begin
          if (mse) begin
            if (SCANMODE == 0) begin
              if (elig[ptr]) begin
                tlineNx = ptr;
                stateNx = HOLD;
              end else begin
                ptrNx = ptr + LB'(1);
              end
            end else if (arbValid) begin
              tlineNx = arbGrant;
              stateNx = HOLD;
            end
          end
        end
        HOLD: begin
          if (!tcrLIN[tline]) stateNx = SCAN;
          else if (tdrLo)     stateNx = WAIT;
        end
        WAIT: begin
          // Resume after the serviced line so every line gets a turn.
          if (!tdrLo) begin
            stateNx = SCAN;
            ptrNx   = tline + LB'(1);
          end
        end
        default: stateNx = SCAN;
      endcase
    end
  end

  assign trdy     = (state != SCAN);
  assign csrMAINT = maint;
  assign txINTR   = tie & trdy;
  assign rxINTR   = rie & (sae ? rbufSA : rbufRDONE);

  // CSR read value.
  always_comb begin
    bus.regCSR                          = '0;
    bus.regCSR[CSR_TRDY]                = trdy;
    bus.regCSR[CSR_TIE]                 = tie;
    bus.regCSR[CSR_SA]                  = rbufSA;
    bus.regCSR[CSR_SAE]                 = sae;
    bus.regCSR[CSR_TLINE +: 4]          = 4'(tline);
    bus.regCSR[CSR_RDONE]               = rbufRDONE;
    bus.regCSR[CSR_RIE]                 = rie;
    bus.regCSR[CSR_MSE]                 = mse;
    bus.regCSR[CSR_CLR]                 = csrCLR;
    bus.regCSR[CSR_MAINT]               = maint;
  end

endmodule

// File: tb/tb_dz_csr_n.sv
module tb_dz_csr_n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        devRESET, devLOBYTE, devHIBYTE, csrWRITE, tdrWRITE;
  logic [0:35] devDATAI;
  logic        rbufRDONE, rbufSA;
  logic [7:0]  tcrLIN0, txe0;
  logic [15:0] tcrLIN1, txe1;
  logic        csrCLR0, csrMAINT0, txINTR0, rxINTR0;
  logic        csrCLR1, csrMAINT1, txINTR1, rxINTR1;

  int checks   = 0;
  int failures = 0;
  int expQ[$];

  always #5 clk = ~clk;

  dz_csr_n_if bus0 ();
  dz_csr_n_if bus1 ();

  assign bus0.devRESET  = devRESET;
  assign bus0.devLOBYTE = devLOBYTE;
  assign bus0.devHIBYTE = devHIBYTE;
  assign bus0.devDATAI  = devDATAI;
  assign bus0.csrWRITE  = csrWRITE;
  assign bus0.tdrWRITE  = tdrWRITE;
  assign bus1.devRESET  = devRESET;
  assign bus1.devLOBYTE = devLOBYTE;
  assign bus1.devHIBYTE = devHIBYTE;
  assign bus1.devDATAI  = devDATAI;
  assign bus1.csrWRITE  = csrWRITE;
  assign bus1.tdrWRITE  = tdrWRITE;

  dz_csr_n dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave),
    .rbufRDONE(rbufRDONE), .rbufSA(rbufSA),
    .uartTXEMPTY(txe0), .tcrLIN(tcrLIN0),
    .csrCLR(csrCLR0), .csrMAINT(csrMAINT0), .txINTR(txINTR0), .rxINTR(rxINTR0)
  );

  dz_csr_n #(.NLINES(16), .SCANMODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
    .rbufRDONE(rbufRDONE), .rbufSA(rbufSA),
    .uartTXEMPTY(txe1), .tcrLIN(tcrLIN1),
    .csrCLR(csrCLR1), .csrMAINT(csrMAINT1), .txINTR(txINTR1), .rxINTR(rxINTR1)
  );

  // One-cycle CSR write driven from a negedge; returns at the negedge after the load edge.
  task automatic csrWr(input logic [15:0] d, input logic lo, input logic hi);
    devDATAI  = {20'h0, d};
    devLOBYTE = lo;
    devHIBYTE = hi;
    csrWRITE  = 1'b1;
    @(negedge clk);
    csrWRITE  = 1'b0;
    devLOBYTE = 1'b0;
    devHIBYTE = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; devRESET = 1'b0; devLOBYTE = 1'b0; devHIBYTE = 1'b0;
    csrWRITE = 1'b0; tdrWRITE = 1'b0; devDATAI = '0;
    rbufRDONE = 1'b0; rbufSA = 1'b1;
    tcrLIN0 = '0; txe0 = 8'hFF; tcrLIN1 = '0; txe1 = 16'hFFFF;
    repeat (2) @(negedge clk);
    checks++; if (bus0.regCSR !== 16'h2000) begin failures++; $display("FAIL reset_csr0 got=%h exp=2000", bus0.regCSR); end
    checks++; if (bus1.regCSR !== 16'h2000) begin failures++; $display("FAIL reset_csr1 got=%h exp=2000", bus1.regCSR); end
    checks++; if ({csrCLR0, csrMAINT0, txINTR0} !== 3'b000) begin failures++; $display("FAIL reset_out0 got=%b exp=000", {csrCLR0, csrMAINT0, txINTR0}); end
    checks++; if ({csrCLR1, csrMAINT1, txINTR1} !== 3'b000) begin failures++; $display("FAIL reset_out1 got=%b exp=000", {csrCLR1, csrMAINT1, txINTR1}); end
    rbufRDONE = 1'b1;
    #1;
    checks++; if (bus0.regCSR !== 16'h2080) begin failures++; $display("FAIL reset_rdone got=%h exp=2080", bus0.regCSR); end
    @(negedge clk);
    rst_n = 1'b1; rbufRDONE = 1'b0; rbufSA = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rw;
    csrWr(16'h5048, 1'b1, 1'b1);
    checks++; if (bus0.regCSR !== 16'h5048) begin failures++; $display("FAIL rw_both got=%h exp=5048", bus0.regCSR); end
    checks++; if (csrMAINT0 !== 1'b1) begin failures++; $display("FAIL rw_maint got=%b exp=1", csrMAINT0); end
    csrWr(16'h0000, 1'b1, 1'b0);
    checks++; if (bus0.regCSR !== 16'h5000) begin failures++; $display("FAIL rw_lo_only got=%h exp=5000", bus0.regCSR); end
    csrWr(16'h4000, 1'b0, 1'b1);
    checks++; if (bus0.regCSR !== 16'h4000) begin failures++; $display("FAIL rw_hi_only got=%h exp=4000", bus0.regCSR); end
  endtask

  task automatic test_clr;
    int cnt, bad, exp;
    csrWr(16'h0040, 1'b1, 1'b0);
    expQ.push_back(180);
    csrWr(16'h0010, 1'b1, 1'b0);
    cnt = 0; bad = 0;
    while (csrCLR0 && cnt < 1000) begin
      if ((bus0.regCSR & 16'h7068) != 16'h0000 || csrMAINT0) bad++;
      if (cnt == 50) begin
        devDATAI = {20'h0, 16'h5068}; devLOBYTE = 1'b1; devHIBYTE = 1'b1; csrWRITE = 1'b1;
      end
      if (cnt == 51) begin
        csrWRITE = 1'b0; devLOBYTE = 1'b0; devHIBYTE = 1'b0;
      end
      cnt++;
      @(negedge clk);
    end
    exp = expQ.pop_front();
    checks++; if (cnt != exp) begin failures++; $display("FAIL clr_len got=%0d exp=%0d", cnt, exp); end
    checks++; if (bad != 0) begin failures++; $display("FAIL clr_bits_held got=%0d exp=0", bad); end
    checks++; if (bus0.regCSR !== 16'h0000) begin failures++; $display("FAIL clr_after got=%h exp=0000", bus0.regCSR); end
  endtask

  task automatic test_scan0;
    int cnt, exp;
    tcrLIN0 = 8'h20;
    expQ.push_back(6);
    csrWr(16'h4020, 1'b1, 1'b1);
    cnt = 0;
    while (!bus0.regCSR[15] && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    exp = expQ.pop_front();
    checks++; if (cnt != exp) begin failures++; $display("FAIL scan0_latency got=%0d exp=%0d", cnt, exp); end
    checks++; if (bus0.regCSR[11:8] !== 4'd5) begin failures++; $display("FAIL scan0_tline got=%0d exp=5", bus0.regCSR[11:8]); end
    checks++; if (txINTR0 !== 1'b1) begin failures++; $display("FAIL scan0_txintr got=%b exp=1", txINTR0); end
  endtask

  task automatic test_hold_drop;
    int cnt, exp;
    tcrLIN0 = 8'h04;
    @(negedge clk);
    checks++; if (bus0.regCSR[15] !== 1'b0) begin failures++; $display("FAIL drop5_trdy got=%b exp=0", bus0.regCSR[15]); end
    expQ.push_back(2);
    cnt = 0;
    while (!bus0.regCSR[15] && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    exp = expQ.pop_front();
    checks++; if (bus0.regCSR[11:8] !== 4'(exp)) begin failures++; $display("FAIL resume_tline got=%0d exp=%0d", bus0.regCSR[11:8], exp); end
    checks++; if (cnt != 6) begin failures++; $display("FAIL resume_latency got=%0d exp=6", cnt); end
    tcrLIN0 = 8'h00;
    @(negedge clk);
    checks++; if (bus0.regCSR[15] !== 1'b0 || txINTR0 !== 1'b0) begin failures++; $display("FAIL drop2_trdy got=%b/%b exp=0/0", bus0.regCSR[15], txINTR0); end
  endtask

  task automatic test_scan1;
    int cnt, exp;
    tcrLIN1 = 16'h0008;
    @(negedge clk);
    checks++; if (bus1.regCSR[15] !== 1'b1 || bus1.regCSR[11:8] !== 4'd3) begin failures++; $display("FAIL rr_first got=%b/%0d exp=1/3", bus1.regCSR[15], bus1.regCSR[11:8]); end
    tcrLIN1 = 16'h1008;
    expQ.push_back(12);
    expQ.push_back(3);
    for (int k = 0; k < 2; k++) begin
      tdrWRITE = 1'b1; devLOBYTE = 1'b1;
      @(negedge clk);
      checks++; if (bus1.regCSR[15] !== 1'b1) begin failures++; $display("FAIL rr_wait_trdy%0d got=%b exp=1", k, bus1.regCSR[15]); end
      tdrWRITE = 1'b0; devLOBYTE = 1'b0;
      @(negedge clk);
      cnt = 1;
      checks++; if (bus1.regCSR[15] !== 1'b0) begin failures++; $display("FAIL rr_scan_trdy%0d got=%b exp=0", k, bus1.regCSR[15]); end
      while (!bus1.regCSR[15] && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      exp = expQ.pop_front();
      checks++; if (bus1.regCSR[11:8] !== 4'(exp) || cnt != 2) begin failures++; $display("FAIL rr_grant%0d got=%0d@%0d exp=%0d@2", k, bus1.regCSR[11:8], cnt, exp); end
    end
  endtask

  task automatic test_reset_clr;
    devRESET = 1'b1;
    devDATAI = {20'h0, 16'h5078}; devLOBYTE = 1'b1; devHIBYTE = 1'b1; csrWRITE = 1'b1;
    @(negedge clk);
    checks++; if (csrCLR0 !== 1'b0) begin failures++; $display("FAIL rstclr_clr got=%b exp=0", csrCLR0); end
    checks++; if (bus0.regCSR !== 16'h0000) begin failures++; $display("FAIL rstclr_csr0 got=%h exp=0000", bus0.regCSR); end
    checks++; if (bus1.regCSR !== 16'h0000) begin failures++; $display("FAIL rstclr_csr1 got=%h exp=0000", bus1.regCSR); end
    devRESET = 1'b0; csrWRITE = 1'b0; devLOBYTE = 1'b0; devHIBYTE = 1'b0;
    @(negedge clk);
    checks++; if (csrCLR0 !== 1'b0 || bus0.regCSR !== 16'h0000) begin failures++; $display("FAIL rstclr_after got=%b/%h exp=0/0000", csrCLR0, bus0.regCSR); end
  endtask

  task automatic test_rxintr;
    rbufRDONE = 1'b1; rbufSA = 1'b0;
    csrWr(16'h1040, 1'b1, 1'b1);
    checks++; if (bus0.regCSR !== 16'h10C0) begin failures++; $display("FAIL rx_csr got=%h exp=10c0", bus0.regCSR); end
    checks++; if (rxINTR0 !== 1'b0) begin failures++; $display("FAIL rx_sae_nosa got=%b exp=0", rxINTR0); end
    rbufSA = 1'b1;
    #1;
    checks++; if (rxINTR0 !== 1'b1 || rxINTR1 !== 1'b1) begin failures++; $display("FAIL rx_sae_sa got=%b/%b exp=1/1", rxINTR0, rxINTR1); end
    @(negedge clk);
    rbufSA = 1'b0;
    csrWr(16'h0040, 1'b1, 1'b1);
    checks++; if (rxINTR0 !== 1'b1) begin failures++; $display("FAIL rx_rdone got=%b exp=1", rxINTR0); end
    rbufRDONE = 1'b0;
    #1;
    checks++; if (rxINTR0 !== 1'b0) begin failures++; $display("FAIL rx_idle got=%b exp=0", rxINTR0); end
    @(negedge clk);
  endtask

  task automatic test_midreset;
    csrWr(16'h0010, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    checks++; if (csrCLR0 !== 1'b1) begin failures++; $display("FAIL mid_clr_active got=%b exp=1", csrCLR0); end
    rst_n = 1'b0;
    #1;
    checks++; if (csrCLR0 !== 1'b0 || bus0.regCSR !== 16'h0000) begin failures++; $display("FAIL mid_abort got=%b/%h exp=0/0000", csrCLR0, bus0.regCSR); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (csrCLR0 !== 1'b0) begin failures++; $display("FAIL mid_residual got=%b exp=0", csrCLR0); end
  endtask

  initial begin
    test_reset();
    test_rw();
    test_clr();
    test_scan0();
    test_hold_drop();
    test_scan1();
    test_reset_clr();
    test_rxintr();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
